// File: rtl/core_ctrl.sv
// core_ctrl -- multi-cycle control FSM for the core.
//
// Sequences every instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// It drives the datapath enables and mux selects, runs the imem/dmem
// request/acknowledge handshakes, and traps on illegal opcodes or on a bus
// that does not acknowledge within MEM_TIMEOUT cycles.
//
// Parameters
//   MEM_TIMEOUT  wait limit for imem_ack/dmem_ack (1 .. 2^TO_W-1)
//   TO_W         width of the wait counter
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   run           level, lets the FSM leave IDLE
//   opcode        instr[6:0] from the IR, valid from DECODE onwards
//   branch_taken  ALU compare result, used in EXEC of a BRANCH
//   imem_req/ack  instruction fetch handshake
//   dmem_req/ack  data access handshake, dmem_we = 1 for a store
//   ir_we         latch the fetched instruction
//   pc_we/pc_sel  PC update; pc_sel 0 = PC+4, 1 = branch/jump target
//   reg_we        register file write enable
//   sel_src_b     ALU operand-B select:
//                 0 = RS2, 1 = IMM, 2 = IMMS12, 3 = constant 4, 4 = constant 12
//   state         current FSM state, for debug
//   trap          sticky fault flag, cleared only by rst
module core_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       reg_we,
  output logic [2:0] sel_src_b,
  output logic [2:0] state,
  output logic       trap
);

  localparam logic [2:0] SEL_SRC_B_RS2    = 3'd0;
  localparam logic [2:0] SEL_SRC_B_IMM    = 3'd1;
  localparam logic [2:0] SEL_SRC_B_IMMS12 = 3'd2;
  localparam logic [2:0] SEL_SRC_B_4      = 3'd3;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [TO_W-1:0] TIMEOUT_LIMIT = TO_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  state_t          cur_state;
  state_t          next_state;
  logic [TO_W-1:0] wait_count;
  logic            is_legal;
  logic            is_load;
  logic            is_store;
  logic            is_branch;
  logic            is_jump;
  logic            timed_out;

  // Opcode classification shared by the next-state and output logic.
  always_comb begin
    is_legal  = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    case (opcode)
      OP_ALU, OP_IMM, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      OP_LOAD: begin
        is_legal = 1'b1;
        is_load  = 1'b1;
      end
      OP_STORE: begin
        is_legal = 1'b1;
        is_store = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        is_legal = 1'b1;
        is_jump  = 1'b1;
      end
      OP_BRANCH: begin
        is_legal  = 1'b1;
        is_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // The limit is reached on the cycle the counter equals MEM_TIMEOUT; an
  // acknowledge arriving in that same cycle still takes priority.
  assign timed_out = (wait_count == TIMEOUT_LIMIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Wait counter for the bus handshakes. Any state change clears it, so it
  // starts from zero on every entry into FETCH or MEM, and it only advances
  // while a request is outstanding without an acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_count <= '0;
    end else if (next_state != cur_state) begin
      wait_count <= '0;
    end else if (((cur_state == S_FETCH) && !imem_ack) ||
                 ((cur_state == S_MEM) && !dmem_ack)) begin
      wait_count <= wait_count + 1'b1;
    end
  end

  // Next-state logic. Once an instruction has left IDLE the FSM never goes
  // back there, so run only matters before the first fetch.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IDLE: begin
        if (run) next_state = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack)       next_state = S_DECODE;
        else if (timed_out) next_state = S_TRAP;
      end
      S_DECODE: begin
        next_state = is_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (is_load || is_store) next_state = S_MEM;
        else if (is_branch)      next_state = S_FETCH;
        else                     next_state = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)       next_state = is_store ? S_FETCH : S_WB;
        else if (timed_out) next_state = S_TRAP;
      end
      S_WB:    next_state = S_FETCH;
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_TRAP;
    endcase
  end

  // Output decode from state and opcode. The ack-qualified enables (ir_we,
  // store pc_we) and the branch pc_sel follow their inputs in the same cycle.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    reg_we    = 1'b0;
    trap      = 1'b0;
    sel_src_b = SEL_SRC_B_RS2;
    case (cur_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_EXEC: begin
        case (opcode)
          OP_IMM, OP_LOAD, OP_STORE: sel_src_b = SEL_SRC_B_IMM;
          OP_LUI, OP_AUIPC:          sel_src_b = SEL_SRC_B_IMMS12;
          OP_JAL, OP_JALR:           sel_src_b = SEL_SRC_B_4;
          default:                   sel_src_b = SEL_SRC_B_RS2;
        endcase
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        pc_we    = dmem_ack && is_store;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_sel = is_jump;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl -- self-checking bench for core_ctrl.
//
// Each instruction is planned as a list of cycles from the handshake delays
// and the opcode, and the cycle's expected output vector is queued next to
// the inputs that are driven. A single compare process checks every queued
// cycle. Directed cases pin the plan itself with hand-computed counts.
module tb_core_ctrl;

  localparam int TIMEOUT = 4;

  localparam logic [2:0] B_RS2    = 3'd0;
  localparam logic [2:0] B_IMM    = 3'd1;
  localparam logic [2:0] B_IMMS12 = 3'd2;
  localparam logic [2:0] B_FOUR   = 3'd3;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       imem_req;
  logic       imem_ack = 1'b0;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack = 1'b0;
  logic       ir_we;
  logic       pc_we;
  logic       pc_sel;
  logic       reg_we;
  logic [2:0] sel_src_b;
  logic [2:0] state;
  logic       trap;

  always #5 clk = ~clk;

  core_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .sel_src_b(sel_src_b), .state(state), .trap(trap)
  );

  // Vector layout: state[13:11] trap[10] imem_req[9] dmem_req[8] dmem_we[7]
  // ir_we[6] pc_we[5] pc_sel[4] reg_we[3] sel_src_b[2:0]
  logic [13:0] dut_vec;
  assign dut_vec = {state, trap, imem_req, dmem_req, dmem_we, ir_we,
                    pc_we, pc_sel, reg_we, sel_src_b};

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [13:0] exp_q[$];
  string       tag_q[$];
  logic [13:0] obs_q[$];
  bit          trapped = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Compare process: every queued cycle is checked half a cycle after drive.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      obs_q.push_back(dut_vec);
      check_output(t, 32'(dut_vec), 32'(e));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [13:0] mk(input int st, input bit tr, input bit ireq,
                                     input bit dreq, input bit dwe, input bit irwe,
                                     input bit pcwe, input bit pcsel, input bit regwe,
                                     input logic [2:0] sel);
    return {3'(st), tr, ireq, dreq, dwe, irwe, pcwe, pcsel, regwe, sel};
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {OP_ALU, OP_IMM, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC,
                      OP_JAL, OP_JALR, OP_BRANCH};
  endfunction

  function automatic logic [2:0] exec_sel(input logic [6:0] op);
    if (op inside {OP_IMM, OP_LOAD, OP_STORE}) return B_IMM;
    if (op inside {OP_LUI, OP_AUIPC})          return B_IMMS12;
    if (op inside {OP_JAL, OP_JALR})           return B_FOUR;
    return B_RS2;
  endfunction

  function automatic int count_bit(input int pos);
    int c = 0;
    foreach (obs_q[i]) c += int'(obs_q[i][pos]);
    return c;
  endfunction

  function automatic int count_state(input int s);
    int c = 0;
    foreach (obs_q[i]) if (int'(obs_q[i][13:11]) == s) c++;
    return c;
  endfunction

  // Drive one cycle of inputs just after the edge and queue its expectation.
  task automatic apply_stimulus(input logic [6:0] op, input bit ia, input bit da,
                                input bit bt, input bit rn, input logic [13:0] e,
                                input string tag);
    @(posedge clk);
    #1;
    opcode       = op;
    imem_ack     = ia;
    dmem_ack     = da;
    branch_taken = bt;
    run          = rn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle_cycles(input int n, input bit go);
    for (int i = 0; i < n; i++)
      apply_stimulus(7'($urandom), rbit(), rbit(), rbit(), 1'b0,
                     mk(0, 0, 0, 0, 0, 0, 0, 0, 0, B_RS2), "idle");
    if (go)
      apply_stimulus(7'($urandom), rbit(), rbit(), rbit(), 1'b1,
                     mk(0, 0, 0, 0, 0, 0, 0, 0, 0, B_RS2), "idle_go");
  endtask

  task automatic trap_cycles(input int n, input bit force_run);
    for (int i = 0; i < n; i++)
      apply_stimulus(7'($urandom), rbit(), rbit(), rbit(), force_run | rbit(),
                     mk(7, 1, 0, 0, 0, 0, 0, 0, 0, B_RS2), "trap");
  endtask

  // One instruction starting in its first FETCH cycle. A handshake lasts
  // delay+1 cycles, but never more than TIMEOUT+1; past that it traps.
  task automatic run_instr(input logic [6:0] op, input int fdelay, input int ddelay,
                           input bit taken, input bit abort_mem);
    bit ld, st, br, jmp, ack;
    int n;
    ld  = (op == OP_LOAD);
    st  = (op == OP_STORE);
    br  = (op == OP_BRANCH);
    jmp = (op == OP_JAL) || (op == OP_JALR);

    n = (fdelay > TIMEOUT) ? TIMEOUT + 1 : fdelay + 1;
    for (int k = 0; k < n; k++) begin
      ack = (k == fdelay);
      apply_stimulus(7'($urandom), ack, rbit(), rbit(), rbit(),
                     mk(1, 0, 1, 0, 0, ack, 0, 0, 0, B_RS2), "fetch");
    end
    if (fdelay > TIMEOUT) begin
      trapped = 1'b1;
      return;
    end

    apply_stimulus(op, rbit(), rbit(), rbit(), rbit(),
                   mk(2, 0, 0, 0, 0, 0, 0, 0, 0, B_RS2), "decode");
    if (!legal_op(op)) begin
      trapped = 1'b1;
      return;
    end

    apply_stimulus(op, rbit(), rbit(), taken, rbit(),
                   mk(3, 0, 0, 0, 0, 0, br, br & taken, 0, exec_sel(op)), "exec");
    if (br) return;

    if (ld || st) begin
      n = (ddelay > TIMEOUT) ? TIMEOUT + 1 : ddelay + 1;
      for (int k = 0; k < n; k++) begin
        ack = (k == ddelay);
        apply_stimulus(op, rbit(), ack, rbit(), rbit(),
                       mk(4, 0, 0, 1, st, 0, ack & st, 0, 0, B_RS2), "mem");
        if (abort_mem) return;
      end
      if (ddelay > TIMEOUT) begin
        trapped = 1'b1;
        return;
      end
      if (st) return;
    end

    apply_stimulus(op, rbit(), rbit(), rbit(), rbit(),
                   mk(5, 0, 0, 0, 0, 0, 1, jmp, 1, B_RS2), "wb");
  endtask

  // Assert reset in the second half of the current cycle and check that the
  // outputs fall to their reset values without waiting for a clock edge.
  task automatic do_reset(input bit mid_mem);
    @(negedge clk);
    #1;
    if (mid_mem) check_output("rst_pre_dmem_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    run = 1'b0;
    #1;
    check_output("rst_async_outputs", 32'(dut_vec), 32'h0);
    @(posedge clk);
    #2;
    check_output("rst_held_state", 32'(state), 32'd0);
    rst     = 1'b0;
    trapped = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] ops[9] = '{OP_ALU, OP_IMM, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC,
                          OP_JAL, OP_JALR, OP_BRANCH};
    if ($urandom_range(0, 99) < 90) return ops[$urandom_range(0, 8)];
    return 7'($urandom);
  endfunction

  function automatic int pick_delay();
    if ($urandom_range(0, 99) < 5) return 99;
    return $urandom_range(0, TIMEOUT);
  endfunction

  initial begin
    int sig;
    $display("[TB] start");
    do_reset(1'b0);
    idle_cycles(3, 1'b1);

    // ADD with immediate acks: FETCH, DECODE, EXEC, WB.
    obs_q.delete();
    run_instr(OP_ALU, 0, 0, 1'b0, 1'b0);
    settle();
    sig = 0;
    foreach (obs_q[i]) sig = sig * 16 + int'(obs_q[i][13:11]);
    check_output("add_state_seq", 32'(sig), 32'h1235);
    check_output("add_reg_we_cycles", 32'(count_bit(3)), 32'd1);
    check_output("add_exec_sel", 32'(obs_q[2][2:0]), 32'd0);

    // Load with dmem_ack three cycles late.
    obs_q.delete();
    run_instr(OP_LOAD, 0, 3, 1'b0, 1'b0);
    settle();
    check_output("lw_cycles", 32'(obs_q.size()), 32'd8);
    check_output("lw_dmem_req_cycles", 32'(count_bit(8)), 32'd4);
    check_output("lw_dmem_we_cycles", 32'(count_bit(7)), 32'd0);
    check_output("lw_reg_we_cycles", 32'(count_bit(3)), 32'd1);

    // Taken branch: redirect in EXEC, no register write.
    obs_q.delete();
    run_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0);
    settle();
    check_output("beq_cycles", 32'(obs_q.size()), 32'd3);
    check_output("beq_exec_pc_we_sel", 32'(obs_q[2][5:4]), 32'b11);
    check_output("beq_reg_we_cycles", 32'(count_bit(3)), 32'd0);

    // imem_ack on the last allowed cycle still wins over the timeout.
    obs_q.delete();
    run_instr(OP_ALU, TIMEOUT, 0, 1'b0, 1'b0);
    settle();
    check_output("fetch_late_ack_cycles", 32'(count_state(1)), 32'd5);
    check_output("fetch_late_ack_trap", 32'(count_bit(10)), 32'd0);

    // imem_ack never arrives: trap after five FETCH cycles.
    obs_q.delete();
    run_instr(OP_ALU, 99, 0, 1'b0, 1'b0);
    trap_cycles(3, 1'b1);
    settle();
    check_output("fetch_timeout_cycles", 32'(count_state(1)), 32'd5);
    check_output("fetch_timeout_trap", 32'(count_state(7)), 32'd3);
    do_reset(1'b0);
    idle_cycles(1, 1'b1);

    // Illegal opcode: trap holds for 100 cycles with run high.
    obs_q.delete();
    run_instr(7'b0000000, 0, 0, 1'b0, 1'b0);
    trap_cycles(100, 1'b1);
    settle();
    check_output("illegal_trap_cycles", 32'(count_bit(10)), 32'd100);
    do_reset(1'b0);
    idle_cycles(2, 1'b1);

    // Reset while a load is waiting in MEM.
    run_instr(OP_LOAD, 0, 3, 1'b0, 1'b1);
    do_reset(1'b1);
    idle_cycles(1, 1'b1);

    // Random instruction stream, recovering from traps with a reset.
    for (int i = 0; i < 300; i++) begin
      run_instr(pick_op(), pick_delay(), pick_delay(), rbit(), 1'b0);
      if (trapped) begin
        trap_cycles($urandom_range(1, 3), 1'b0);
        do_reset(1'b0);
        idle_cycles($urandom_range(0, 2), 1'b1);
      end
    end

    settle();
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
